// File: rtl/fetch_unit_32_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and instruction memory (slave).
interface fetch_unit_32_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_unit_32.sv
// Fetch stage: owns the PC, issues single-outstanding word fetches and feeds the decoder register.
// Optional FETCH_COUNTERS_EN adds fetch_count / bubble_count performance counters.
//
// state   | meaning
// S_START | post-reset idle cycle, no request
// S_FETCH | request outstanding at pc, waiting for/accepting a response
// S_HOLD  | downstream stalled on a live word with no response pending; request dropped
module fetch_unit_32 #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    fetch_unit_32_if.master        imem,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_target,
    output logic [31:0]            instruction,
    output logic                   instruction_valid,
    output logic [31:0]            instruction_pc,
    output logic [31:0]            pc_plus4
`ifdef FETCH_COUNTERS_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [31:0]            bubble_count
`endif
);

    typedef enum logic [1:0] {S_START, S_FETCH, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] ipc_q, ipc_d;
    logic        accept;

    // Redirect targets are word aligned; the low bits are dropped on purpose.
    logic unused_target_bits;
    assign unused_target_bits = ^redirect_target[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        ipc_d   = ipc_q;
        accept  = (state_q == S_FETCH) && imem.imem_ready && (!valid_q || !stall);

        if (redirect_valid) begin
            pc_d    = {redirect_target[31:2], 2'b00};
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_START: state_d = S_FETCH;
                S_FETCH: begin
                    if (accept) begin
                        instr_d = imem.imem_rdata;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end else if (!imem.imem_ready) begin
                        if (!stall) begin
                            valid_d = 1'b0;
                            instr_d = NOP_WORD;
                        end else if (valid_q) begin
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // Decoder takes the held word this cycle; a bubble follows while the request restarts.
                    if (!stall) begin
                        state_d = S_FETCH;
                        valid_d = 1'b0;
                        instr_d = NOP_WORD;
                    end
                end
                default: state_d = S_START;
            endcase
        end

        req_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_START;
            pc_q    <= RESET_VECTOR;
            req_q   <= 1'b0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            ipc_q   <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            ipc_q   <= ipc_d;
        end
    end

    assign imem.imem_req     = req_q;
    assign imem.imem_addr    = pc_q;
    assign instruction       = instr_q;
    assign instruction_valid = valid_q;
    assign instruction_pc    = ipc_q;
    assign pc_plus4          = ipc_q + 32'd4;

`ifdef FETCH_COUNTERS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else begin
            if (accept)
                fetch_count <= fetch_count + 32'd1;
            if ((state_q != S_START) && !valid_q && !stall)
                bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule
